// File: rtl/mmu_pkg.sv
// Shared types and helpers for the region-table MMU router.
package mmu_pkg;

  localparam int unsigned MEM_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [31:0] base;
    logic [5:0]  size_log2;
    logic        ro;
  } region_cfg_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmu_region_decoder.sv
// Combinational address decoder: lowest-index matching region wins.
module mmu_region_decoder
  import mmu_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 4
) (
  input  logic [31:0]                    addr,
  input  region_cfg_t [NUM_REGIONS-1:0]  cfg,
  output logic                           hit,
  output logic [NUM_REGIONS-1:0]         sel,
  output logic [31:0]                    offset,
  output logic                           ro
);

  logic [NUM_REGIONS-1:0][31:0] mask;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_mask
    assign mask[g] = (cfg[g].size_log2 >= 6'd32) ? 32'h0 : (32'hFFFF_FFFF << cfg[g].size_log2);
  end

  always_comb begin
    hit    = 1'b0;
    sel    = '0;
    offset = '0;
    ro     = 1'b0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!hit && ((addr & mask[i]) == (cfg[i].base & mask[i]))) begin
        hit    = 1'b1;
        sel[i] = 1'b1;
        offset = addr & ~mask[i];
        ro     = cfg[i].ro;
      end
    end
  end

endmodule

// File: rtl/mmu_router.sv
// Routes single-outstanding host requests to region-mapped device ports,
// with read-only protection, response timeout/abort and error responses.
module mmu_router
  import mmu_pkg::*;
#(
  parameter int unsigned                   MEM_W            = MEM_W_DEFAULT,
  parameter int unsigned                   NUM_REGIONS      = 4,
  parameter logic [NUM_REGIONS-1:0][31:0]  REGION_BASE      = {32'h0100_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0100},
  parameter logic [NUM_REGIONS-1:0][31:0]  REGION_SIZE_LOG2 = {32'd24, 32'd13, 32'd12, 32'd8},
  parameter logic [NUM_REGIONS-1:0]        REGION_RO        = '0,
  parameter int unsigned                   TIMEOUT_CYCLES   = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_i,
  input  logic [31:0]                    addr_i,
  input  logic                           we_i,
  input  logic [MEM_W/8-1:0]             be_i,
  input  logic [MEM_W-1:0]               wdata_i,
  output logic                           gnt_o,
  output logic                           rvalid_o,
  output logic                           err_o,
  output logic [MEM_W-1:0]               rdata_o,
  output logic [NUM_REGIONS-1:0]         dev_req_o,
  output logic [31:0]                    dev_addr_o,
  output logic                           dev_we_o,
  output logic [MEM_W/8-1:0]             dev_be_o,
  output logic [MEM_W-1:0]               dev_wdata_o,
  output logic [NUM_REGIONS-1:0]         dev_abort_o,
  input  logic [NUM_REGIONS-1:0]         dev_rvalid_i,
  input  logic [NUM_REGIONS-1:0]         dev_err_i,
  input  logic [NUM_REGIONS*MEM_W-1:0]   dev_rdata_i
);

  localparam int unsigned BE_W  = MEM_W / 8;
  localparam int unsigned CNT_W = clog2_min1(TIMEOUT_CYCLES);

  if (MEM_W == 0 || (MEM_W % 8) != 0) begin : g_bad_mem_w
    $fatal(1, "mmu_router: MEM_W must be a non-zero multiple of 8");
  end
  if (NUM_REGIONS < 1 || NUM_REGIONS > 16) begin : g_bad_num
    $fatal(1, "mmu_router: NUM_REGIONS must be 1..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $fatal(1, "mmu_router: TIMEOUT_CYCLES must be >= 2");
  end

  region_cfg_t [NUM_REGIONS-1:0] cfg;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_cfg
    if (REGION_SIZE_LOG2[g] > 32) begin : g_bad_size
      $fatal(1, "mmu_router: REGION_SIZE_LOG2[%0d] exceeds 32", g);
    end
    if ((REGION_BASE[g] & ~(32'hFFFF_FFFF << REGION_SIZE_LOG2[g])) != 32'h0) begin : g_bad_align
      $fatal(1, "mmu_router: REGION_BASE[%0d] not aligned to its size", g);
    end
    assign cfg[g] = '{base: REGION_BASE[g], size_log2: REGION_SIZE_LOG2[g][5:0], ro: REGION_RO[g]};
  end

  logic                   dec_hit;
  logic [NUM_REGIONS-1:0] dec_sel;
  logic [31:0]            dec_offset;
  logic                   dec_ro;

  mmu_region_decoder #(
    .NUM_REGIONS(NUM_REGIONS)
  ) u_decoder (
    .addr   (addr_i),
    .cfg    (cfg),
    .hit    (dec_hit),
    .sel    (dec_sel),
    .offset (dec_offset),
    .ro     (dec_ro)
  );

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt;
  logic [31:0]            addr_q;
  logic                   we_q;
  logic [BE_W-1:0]        be_q;
  logic [MEM_W-1:0]       wdata_q;
  logic [NUM_REGIONS-1:0] sel_q;
  logic                   err_q;
  logic [MEM_W-1:0]       rdata_q;

  logic                   rv_sel;
  logic                   err_sel;
  logic [MEM_W-1:0]       rdata_sel;
  logic                   timeout;

  assign rv_sel  = |(dev_rvalid_i & sel_q);
  assign err_sel = |(dev_err_i & sel_q);

  always_comb begin
    rdata_sel = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (sel_q[i]) rdata_sel = dev_rdata_i[i*MEM_W +: MEM_W];
    end
  end

  // A response in the final counted cycle takes precedence over the timeout.
  assign timeout = (state == WAIT) && !rv_sel && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (req_i) state_next = (!dec_hit || (we_i && dec_ro)) ? RESP : ISSUE;
      ISSUE: state_next = rv_sel ? RESP : WAIT;
      WAIT:  if (rv_sel || timeout) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (req_i) begin
          addr_q  <= dec_offset;
          we_q    <= we_i;
          be_q    <= be_i;
          wdata_q <= wdata_i;
          sel_q   <= dec_sel;
          err_q   <= !dec_hit || (we_i && dec_ro);
          rdata_q <= '0;
        end
        ISSUE: begin
          cnt <= '0;
          if (rv_sel) begin
            err_q   <= err_sel;
            rdata_q <= rdata_sel;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (rv_sel) begin
            err_q   <= err_sel;
            rdata_q <= rdata_sel;
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt_o       = (state == IDLE);
  assign rvalid_o    = (state == RESP);
  assign err_o       = (state == RESP) && err_q;
  assign rdata_o     = ((state == RESP) && !err_q && !we_q) ? rdata_q : '0;
  assign dev_req_o   = (state == ISSUE) ? sel_q : '0;
  assign dev_abort_o = timeout ? sel_q : '0;
  assign dev_addr_o  = addr_q;
  assign dev_we_o    = we_q;
  assign dev_be_o    = be_q;
  assign dev_wdata_o = wdata_q;

endmodule

// File: tb/tb_mmu_router.sv
// Directed and randomized bench for mmu_router against an arithmetic region-map model.
module tb_mmu_router;

  localparam int unsigned TO = 256;
  localparam logic [3:0]  RO = 4'b0100;
  localparam logic [31:0] BASES [4] = '{32'h0000_0100, 32'h0000_1000, 32'h0000_2000, 32'h0100_0000};
  localparam int unsigned SZ [4]    = '{8, 12, 13, 24};
  localparam logic [31:0] UNMAPPED [5] = '{32'h0000_0050, 32'h0000_0200, 32'h0000_4000, 32'h0200_0000, 32'hFFFF_FFFC};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic         we_i = 1'b0;
  logic [3:0]   be_i = '0;
  logic [31:0]  wdata_i = '0;
  logic         gnt_o, rvalid_o, err_o;
  logic [31:0]  rdata_o;
  logic [3:0]   dev_req_o, dev_abort_o;
  logic [31:0]  dev_addr_o;
  logic         dev_we_o;
  logic [3:0]   dev_be_o;
  logic [31:0]  dev_wdata_o;
  logic [3:0]   dev_rvalid_i = '0;
  logic [3:0]   dev_err_i = '0;
  logic [127:0] dev_rdata_i = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mmu_router #(
    .MEM_W(32),
    .NUM_REGIONS(4),
    .REGION_RO(RO),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
    .dev_req_o(dev_req_o), .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o), .dev_be_o(dev_be_o),
    .dev_wdata_o(dev_wdata_o), .dev_abort_o(dev_abort_o), .dev_rvalid_i(dev_rvalid_i),
    .dev_err_i(dev_err_i), .dev_rdata_i(dev_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_region(input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      longint unsigned lo = 64'(BASES[i]);
      longint unsigned hi = lo + (64'd1 << SZ[i]);
      if (64'(a) >= lo && 64'(a) < hi) return i;
    end
    return -1;
  endfunction

  task automatic noise(input logic [3:0] excl);
    dev_rvalid_i = 4'($urandom) & ~excl;
    dev_err_i    = 4'($urandom);
    for (int k = 0; k < 4; k++) dev_rdata_i[k*32 +: 32] = $urandom;
  endtask

  task automatic drive_resp(input int r, input logic derr, input logic [31:0] rd);
    dev_rvalid_i[r]          = 1'b1;
    dev_err_i[r]             = derr;
    dev_rdata_i[r*32 +: 32]  = rd;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt_o), 32'd1);
    chk({tag, "_rvalid"}, 32'(rvalid_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_rdata"}, rdata_o, 32'd0);
    chk({tag, "_dev_req"}, 32'(dev_req_o), 32'd0);
    chk({tag, "_abort"}, 32'(dev_abort_o), 32'd0);
    chk({tag, "_dev_addr"}, dev_addr_o, 32'd0);
    chk({tag, "_dev_we"}, 32'(dev_we_o), 32'd0);
    chk({tag, "_dev_be"}, 32'(dev_be_o), 32'd0);
    chk({tag, "_dev_wdata"}, dev_wdata_o, 32'd0);
  endtask

  // resp_at < 0: device stays silent; 0: responds in ISSUE; N: responds in WAIT cycle N.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] wd, input int resp_at, input logic derr,
                         input logic [31:0] rd, input bit hold);
    int         r      = model_region(a);
    bit         early  = (r < 0) || (w && RO[r]);
    bit         silent = (resp_at < 0);
    logic [3:0] onehot = '0;
    int         last;
    bit         exp_err;
    if (r >= 0) onehot = 4'b0001 << r;

    req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = wd;
    noise(4'b0000);
    #1;
    chk("accept_gnt", 32'(gnt_o), 32'd1);
    chk("accept_rvalid", 32'(rvalid_o), 32'd0);
    tick();
    if (!hold) begin
      req_i = 1'b0; addr_i = $urandom; we_i = 1'($urandom); be_i = 4'($urandom); wdata_i = $urandom;
    end

    if (early) begin
      noise(4'b0000);
      #1;
      chk("early_dev_req", 32'(dev_req_o), 32'd0);
      chk("early_rvalid", 32'(rvalid_o), 32'd1);
      chk("early_err", 32'(err_o), 32'd1);
      chk("early_rdata", rdata_o, 32'd0);
      chk("early_gnt", 32'(gnt_o), 32'd0);
      tick();
      return;
    end

    noise(onehot);
    if (resp_at == 0) drive_resp(r, derr, rd);
    #1;
    chk("issue_dev_req", 32'(dev_req_o), 32'(onehot));
    chk("issue_dev_addr", dev_addr_o, a - BASES[r]);
    chk("issue_dev_we", 32'(dev_we_o), 32'(w));
    chk("issue_dev_be", 32'(dev_be_o), 32'(b));
    chk("issue_dev_wdata", dev_wdata_o, wd);
    chk("issue_gnt", 32'(gnt_o), 32'd0);
    chk("issue_rvalid", 32'(rvalid_o), 32'd0);
    chk("issue_abort", 32'(dev_abort_o), 32'd0);
    tick();

    last = silent ? TO : resp_at;
    for (int n = 1; n <= last; n++) begin
      noise(onehot);
      if (n == resp_at) drive_resp(r, derr, rd);
      #1;
      chk("wait_gnt", 32'(gnt_o), 32'd0);
      chk("wait_rvalid", 32'(rvalid_o), 32'd0);
      chk("wait_dev_req", 32'(dev_req_o), 32'd0);
      chk("wait_abort", 32'(dev_abort_o), (silent && n == TO) ? 32'(onehot) : 32'd0);
      chk("wait_dev_addr", dev_addr_o, a - BASES[r]);
      tick();
    end

    noise(4'b0000);
    if (silent) dev_rvalid_i = dev_rvalid_i | onehot;
    exp_err = silent || derr;
    #1;
    chk("resp_rvalid", 32'(rvalid_o), 32'd1);
    chk("resp_err", 32'(err_o), 32'(exp_err));
    chk("resp_rdata", rdata_o, (!w && !exp_err) ? rd : 32'd0);
    chk("resp_gnt", 32'(gnt_o), 32'd0);
    chk("resp_dev_req", 32'(dev_req_o), 32'd0);
    chk("resp_abort", 32'(dev_abort_o), 32'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          kind;
    int          ra;

    #3;
    check_reset_outputs("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();

    run_txn(32'h0000_1004, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    run_txn(32'h0000_2010, 1'b1, 4'h3, 32'h1234_5678, 0, 1'b0, 32'h0, 1'b0);
    run_txn(32'h0000_0050, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    run_txn(32'h0000_0104, 1'b0, 4'hF, 32'h0, 1, 1'b0, 32'hCAFE_F00D, 1'b0);

    run_txn(32'h0100_0020, 1'b0, 4'hF, 32'h0, -1, 1'b0, 32'h0, 1'b0);
    noise(4'b0000);
    dev_rvalid_i[3] = 1'b1;
    #1;
    chk("late_rvalid_ignored", 32'(rvalid_o), 32'd0);
    chk("late_gnt", 32'(gnt_o), 32'd1);
    chk("late_dev_req", 32'(dev_req_o), 32'd0);
    tick();

    run_txn(32'h0000_0108, 1'b0, 4'hF, 32'h0, 3, 1'b1, 32'h5555_AAAA, 1'b1);
    run_txn(32'h0000_0108, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h0BAD_F00D, 1'b0);

    req_i = 1'b1; addr_i = 32'h0100_0010; we_i = 1'b0; be_i = 4'hF;
    dev_rvalid_i = '0;
    tick();
    req_i = 1'b0;
    #1;
    chk("rst_issue_dev_req", 32'(dev_req_o), 32'h8);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_gnt", 32'(gnt_o), 32'd1);
    chk("rst_async_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_async_dev_req", 32'(dev_req_o), 32'd0);
    chk("rst_async_abort", 32'(dev_abort_o), 32'd0);
    chk("rst_async_dev_addr", dev_addr_o, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    run_txn(32'h0000_1000, 1'b0, 4'hF, 32'h0, 2, 1'b0, 32'h1357_9BDF, 1'b0);

    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(0, 4));
      if (kind < 4) a = BASES[kind] + ($urandom & ((32'd1 << SZ[kind]) - 32'd1));
      else a = UNMAPPED[$urandom_range(0, 4)];
      ra = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 5));
      run_txn(a, 1'($urandom), 4'($urandom), $urandom, ra, ($urandom_range(0, 3) == 0), $urandom, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
